// File: rtl/isp8_intr_ctrl.sv
// Multi-source interrupt controller for the isp8 core: synchronises and latches irq edges,
// masks them, drives intr against intr_ack and exposes four registers on the port bus.
module isp8_intr_ctrl #(
   parameter int NUM_IRQ     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               intr,
   input  logic               intr_ack,
   input  logic               io_sel,
   input  logic               io_we,
   input  logic [1:0]         io_addr,
   input  logic [7:0]         io_wdata,
   output logic [7:0]         io_rdata,
   output logic               io_ready
);

   typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

   localparam logic [7:0] IRQ_MSK = 8'((9'd1 << NUM_IRQ) - 9'd1);

   logic [7:0] irq_ext;
   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] edge_q;
   logic [7:0] rise;
   logic [7:0] pending_q, pending_d;
   logic [7:0] mask_q, mask_d;
   logic [7:0] active;
   logic [2:0] vec_idx;
   logic [7:0] vec;
   logic [7:0] rd_mux;
   logic [7:0] io_rdata_q;
   logic       io_ready_q;
   logic       held_q;
   logic       start, wr;
   logic       ack_q, ack_rise, ack_fall;
   logic       intr_q;
   logic [2:0] svc_id_q, svc_id_d;
   state_t     state_q, state_d;

   always_comb begin
      irq_ext = '0;
      irq_ext[NUM_IRQ-1:0] = irq_in;
   end

   assign rise  = sync_q[SYNC_STAGES-1] & ~edge_q;
   // held_q blocks a second access until io_sel has been seen low
   assign start = io_sel & ~held_q;
   assign wr    = start & io_we;

   // set is ORed in after the clear so a coincident edge wins
   assign pending_d = ((pending_q & ~((wr && io_addr == 2'd0) ? io_wdata : 8'h00)) | rise) & IRQ_MSK;
   assign mask_d    = (wr && io_addr == 2'd1) ? (io_wdata & IRQ_MSK) : mask_q;
   assign active    = pending_q & mask_q;

   always_comb begin
      vec_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (active[i]) vec_idx = 3'(i);
      end
   end

   assign vec = {|active, 4'b0000, (|active) ? vec_idx : 3'd0};

   always_comb begin
      rd_mux = 8'h00;
      case (io_addr)
         2'd0: rd_mux = pending_q;
         2'd1: rd_mux = mask_q;
         2'd2: rd_mux = vec;
         2'd3: rd_mux = {state_q == SVC, 4'b0000, svc_id_q};
         default: rd_mux = 8'h00;
      endcase
   end

   assign ack_rise = intr_ack & ~ack_q;
   assign ack_fall = ~intr_ack & ack_q;

   always_comb begin
      state_d  = state_q;
      svc_id_d = svc_id_q;
      case (state_q)
         IDLE: begin
            if (ack_rise) begin
               state_d  = SVC;
               svc_id_d = 3'd0;
            end else if (active != 8'h00) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (ack_rise) begin
               state_d  = SVC;
               svc_id_d = vec[2:0];
            end else if (active == 8'h00) begin
               state_d = IDLE;
            end
         end
         SVC: begin
            if (ack_fall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         edge_q     <= '0;
         pending_q  <= '0;
         mask_q     <= '0;
         held_q     <= 1'b0;
         io_ready_q <= 1'b0;
         io_rdata_q <= '0;
         ack_q      <= 1'b0;
         intr_q     <= 1'b0;
         svc_id_q   <= '0;
         state_q    <= IDLE;
      end else begin
         sync_q[0] <= irq_ext;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         edge_q     <= sync_q[SYNC_STAGES-1];
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         held_q     <= io_sel;
         io_ready_q <= start;
         if (start) io_rdata_q <= rd_mux;
         ack_q      <= intr_ack;
         intr_q     <= (state_d == REQ);
         svc_id_q   <= svc_id_d;
         state_q    <= state_d;
      end
   end

   assign intr     = intr_q;
   assign io_ready = io_ready_q;
   assign io_rdata = io_rdata_q;

endmodule

// File: tb/tb_isp8_intr_ctrl.sv
// Directed bench for isp8_intr_ctrl: register map, priority/vector, request/service
// sequencing, set-vs-clear collision, bus handshake and asynchronous reset.
module tb_isp8_intr_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irq_in;
   logic       intr;
   logic       intr_ack;
   logic       io_sel;
   logic       io_we;
   logic [1:0] io_addr;
   logic [7:0] io_wdata;
   logic [7:0] io_rdata;
   logic       io_ready;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   isp8_intr_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq_in   (irq_in),
      .intr     (intr),
      .intr_ack (intr_ack),
      .io_sel   (io_sel),
      .io_we    (io_we),
      .io_addr  (io_addr),
      .io_wdata (io_wdata),
      .io_rdata (io_rdata),
      .io_ready (io_ready)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bus access; inputs change on the falling edge, io_ready is sampled there too.
   task automatic io_access(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rdata);
      bit got_rdy = 1'b0;
      @(negedge clk);
      io_sel   = 1'b1;
      io_we    = we;
      io_addr  = addr;
      io_wdata = wdata;
      for (int i = 0; i < 10 && !got_rdy; i++) begin
         @(negedge clk);
         if (io_ready) got_rdy = 1'b1;
      end
      if (!got_rdy) begin
         n_cmp++;
         n_err++;
         $display("FAIL io_timeout: no io_ready within 10 cycles, addr %0d", addr);
      end
      rdata  = io_rdata;
      io_sel = 1'b0;
      io_we  = 1'b0;
   endtask

   task automatic rd(input logic [1:0] addr, output logic [7:0] data);
      io_access(1'b0, addr, 8'h00, data);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [7:0] data);
      logic [7:0] dummy;
      io_access(1'b1, addr, data, dummy);
   endtask

   task automatic pulse_irq(input int idx);
      @(negedge clk);
      irq_in[idx] = 1'b1;
      cycles(2);
      irq_in[idx] = 1'b0;
      cycles(4);
   endtask

   logic [7:0] d;
   int         rdy_cnt;
   int         rdy_first;
   bit         seen;

   initial begin
      rst_n    = 1'b0;
      irq_in   = 8'h00;
      intr_ack = 1'b0;
      io_sel   = 1'b0;
      io_we    = 1'b0;
      io_addr  = 2'd0;
      io_wdata = 8'h00;
      cycles(3);
      rst_n = 1'b1;
      cycles(2);

      // reset state
      chk("rst_intr", {7'b0, intr}, 8'h00);
      chk("rst_ready", {7'b0, io_ready}, 8'h00);
      rd(2'd0, d); chk("rst_pending", d, 8'h00);
      rd(2'd1, d); chk("rst_mask", d, 8'h00);
      rd(2'd2, d); chk("rst_vector", d, 8'h00);
      rd(2'd3, d); chk("rst_service", d, 8'h00);

      // two masked-in sources, lowest index wins
      wr(2'd1, 8'h24);
      pulse_irq(5);
      pulse_irq(2);
      rd(2'd0, d); chk("t2_pending", d, 8'h24);
      rd(2'd2, d); chk("t2_vector", d, 8'h82);
      chk("t2_intr_req", {7'b0, intr}, 8'h01);
      @(negedge clk); intr_ack = 1'b1;
      cycles(2);
      chk("t2_intr_svc", {7'b0, intr}, 8'h00);
      rd(2'd3, d); chk("t2_service", d, 8'h82);
      wr(2'd0, 8'h04);
      @(negedge clk); intr_ack = 1'b0;
      cycles(3);
      chk("t2_intr_rereq", {7'b0, intr}, 8'h01);
      rd(2'd2, d); chk("t2_vector2", d, 8'h85);
      rd(2'd3, d); chk("t2_service2", d, 8'h02);
      wr(2'd0, 8'h20);
      cycles(2);
      chk("t2_intr_cleared", {7'b0, intr}, 8'h00);

      // pending while masked, then unmask
      wr(2'd1, 8'h00);
      pulse_irq(3);
      rd(2'd0, d); chk("t3_pending", d, 8'h08);
      chk("t3_intr_masked", {7'b0, intr}, 8'h00);
      wr(2'd1, 8'h08);
      seen = 1'b0;
      for (int i = 0; i < 2 && !seen; i++) begin
         @(negedge clk);
         if (intr) seen = 1'b1;
      end
      chk("t3_intr_unmask", {7'b0, seen}, 8'h01);
      wr(2'd0, 8'h08);
      cycles(2);

      // request withdrawn by masking before ack
      wr(2'd1, 8'h02);
      pulse_irq(1);
      chk("t4_intr_req", {7'b0, intr}, 8'h01);
      wr(2'd1, 8'h00);
      cycles(2);
      chk("t4_intr_drop", {7'b0, intr}, 8'h00);
      rd(2'd3, d); chk("t4_service", d, 8'h02);
      rd(2'd0, d); chk("t4_pending", d, 8'h02);
      wr(2'd0, 8'h02);

      // edge reaches pending on the same clock as a W1C of that bit
      @(negedge clk); irq_in[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      io_sel = 1'b1; io_we = 1'b1; io_addr = 2'd0; io_wdata = 8'h01;
      @(negedge clk);
      chk("t5_ready", {7'b0, io_ready}, 8'h01);
      io_sel = 1'b0; io_we = 1'b0; irq_in[0] = 1'b0;
      rd(2'd0, d); chk("t5_set_wins", d, 8'h01);

      // io_sel held high: a single access
      @(negedge clk);
      io_sel = 1'b1; io_we = 1'b0; io_addr = 2'd1;
      rdy_cnt = 0; rdy_first = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (io_ready) begin
            rdy_cnt++;
            if (rdy_first == 0) rdy_first = i;
         end
      end
      io_sel = 1'b0;
      chk("t6_ready_count", 8'(rdy_cnt), 8'h01);
      chk("t6_ready_cycle", 8'(rdy_first), 8'h01);

      // reset during a request
      wr(2'd1, 8'h01);
      cycles(2);
      chk("t7_intr_req", {7'b0, intr}, 8'h01);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t7_intr_rst", {7'b0, intr}, 8'h00);
      cycles(2);
      rst_n = 1'b1;
      cycles(1);
      rd(2'd1, d); chk("t7_mask", d, 8'h00);
      rd(2'd0, d); chk("t7_pending", d, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
